pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/cdc_sync2.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 120 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   localparam int DEF_RESET_PULSE_CYCLES  = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 1048576;
   localparam int DEF_CNT_W               = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module cdc_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // shift the asynchronous input through two flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, waits for a stable lock, then
// releases downstream reset. Lock loss in RUN or a lock timeout re-resets
// the PLL; a short lock dropout while qualifying only restarts qualification.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | PLL reset pin driven high for RESET_PULSE_CYCLES cycles
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES consecutive lock cycles
// RUN       | lock qualified, downstream reset released
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RESET_PULSE_CYCLES  = DEF_RESET_PULSE_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock_i,
   input  logic             sw_reset_i,
   output logic             pll_reset_o,
   output logic             sys_rst_n_o,
   output logic             locked_o,
   output logic [CNT_W-1:0] relock_count_o,
   output logic [CNT_W-1:0] timeout_count_o
);

   localparam int CYC_MAX = max3(RESET_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   // terminal counts: the counter starts at 0 on state entry
   localparam logic [CYC_W-1:0] RP_LAST = CYC_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [CYC_W-1:0] LS_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);

   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   pll_state_t       state;
   pll_state_t       nxt;
   logic [CYC_W-1:0] cyc;
   logic             lock_s;
   logic             restart;
   logic             relock_inc;
   logic             timeout_inc;

   cdc_sync2 u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock_i),
      .q     (lock_s)
   );

   // next-state decode; a software restart overrides every other transition
   always_comb begin
      nxt         = state;
      relock_inc  = 1'b0;
      timeout_inc = 1'b0;
      if (sw_reset_i) begin
         nxt = PLL_RST;
      end else begin
         case (state)
            PLL_RST: begin
               if (cyc == RP_LAST) nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  nxt = STABLE;
               end else if (cyc == TO_LAST) begin
                  nxt         = PLL_RST;
                  timeout_inc = 1'b1;
               end
            end
            STABLE: begin
               if (!lock_s)              nxt = WAIT_LOCK;
               else if (cyc == LS_LAST)  nxt = RUN;
            end
            RUN: begin
               if (!lock_s) begin
                  nxt        = PLL_RST;
                  relock_inc = 1'b1;
               end
            end
            default: nxt = PLL_RST;
         endcase
      end
      // sw_reset in PLL_RST keeps the state but must still restart the pulse
      restart = sw_reset_i || (nxt != state);
   end

   // state, cycle counter, next-state-decoded outputs and event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= PLL_RST;
         cyc             <= '0;
         pll_reset_o     <= 1'b1;
         sys_rst_n_o     <= 1'b0;
         locked_o        <= 1'b0;
         relock_count_o  <= '0;
         timeout_count_o <= '0;
      end else begin
         state <= nxt;
         if (restart)
            cyc <= '0;
         else if (state != RUN)
            cyc <= cyc + 1'b1;

         pll_reset_o <= (nxt == PLL_RST);
         sys_rst_n_o <= (nxt == RUN);
         locked_o    <= (nxt == RUN);

         if (relock_inc && (relock_count_o != CNT_SAT))
            relock_count_o <= relock_count_o + 1'b1;
         if (timeout_inc && (timeout_count_o != CNT_SAT))
            timeout_count_o <= timeout_count_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with pulse=4, stable=8, timeout=32.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock_i;
   logic       sw_reset_i;
   logic       pll_reset_o;
   logic       sys_rst_n_o;
   logic       locked_o;
   logic [7:0] relock_count_o;
   logic [7:0] timeout_count_o;

   int n_cmp = 0;
   int n_bad = 0;

   pll_reset_sequencer #(
      .RESET_PULSE_CYCLES  (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .CNT_W               (8)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pll_lock_i      (pll_lock_i),
      .sw_reset_i      (sw_reset_i),
      .pll_reset_o     (pll_reset_o),
      .sys_rst_n_o     (sys_rst_n_o),
      .locked_o        (locked_o),
      .relock_count_o  (relock_count_o),
      .timeout_count_o (timeout_count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // advance one clock edge; inputs driven and outputs sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      pll_lock_i = 1'b0;
      sw_reset_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_sys(input logic val, input int max_ticks, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max_ticks && !ok) begin
         tick();
         n++;
         if (sys_rst_n_o === val) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int highs;
      int n;
      bit ok;
      rst_n      = 1'b0;
      pll_lock_i = 1'b0;
      sw_reset_i = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if ({pll_reset_o, sys_rst_n_o, locked_o} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_outputs: got rst/sys/lck=%b%b%b want 100", pll_reset_o, sys_rst_n_o, locked_o);
      end
      n_cmp++;
      if (relock_count_o !== 8'd0 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_counters: got %0d/%0d want 0/0", relock_count_o, timeout_count_o);
      end
      rst_n = 1'b1;
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         if (pll_reset_o === 1'b1) highs++;
         tick();
      end
      n_cmp++;
      if (highs != 4) begin
         n_bad++;
         $display("FAIL cold_pulse_width: got %0d want 4", highs);
      end
      pll_lock_i = 1'b1;
      wait_sys(1'b1, 40, n, ok);
      n_cmp++;
      if (!ok || n != 11) begin
         n_bad++;
         $display("FAIL cold_lock_latency: got %0d (ok=%0d) want 11", n, ok);
      end
      n_cmp++;
      if (locked_o !== 1'b1 || pll_reset_o !== 1'b0) begin
         n_bad++;
         $display("FAIL cold_run_outputs: got locked=%b pll_reset=%b want 1/0", locked_o, pll_reset_o);
      end
      n_cmp++;
      if (relock_count_o !== 8'd0 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL cold_counters: got %0d/%0d want 0/0", relock_count_o, timeout_count_o);
      end
   endtask

   task automatic test_lock_glitch();
      int  n;
      bit  ok;
      bit  saw_prst;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      pll_lock_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      pll_lock_i = 1'b0;
      tick();
      pll_lock_i = 1'b1;
      saw_prst = 1'b0;
      n  = 0;
      ok = 1'b0;
      while (n < 30 && !ok) begin
         tick();
         n++;
         if (pll_reset_o !== 1'b0) saw_prst = 1'b1;
         if (sys_rst_n_o === 1'b1) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || n != 11) begin
         n_bad++;
         $display("FAIL glitch_release_latency: got %0d (ok=%0d) want 11", n, ok);
      end
      n_cmp++;
      if (saw_prst) begin
         n_bad++;
         $display("FAIL glitch_no_pll_reset: got pll_reset pulse want none");
      end
      n_cmp++;
      if (relock_count_o !== 8'd0 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL glitch_counters: got %0d/%0d want 0/0", relock_count_o, timeout_count_o);
      end
   endtask

   task automatic test_timeout();
      int   highs;
      int   rises;
      int   rise_t[2];
      logic prev;
      bit   sys_seen;
      do_reset();
      highs    = 0;
      rises    = 0;
      rise_t   = '{-1, -1};
      prev     = 1'b1;
      sys_seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (pll_reset_o === 1'b1) begin
            highs++;
            if (prev !== 1'b1) begin
               if (rises < 2) rise_t[rises] = i;
               rises++;
            end
         end
         if (sys_rst_n_o !== 1'b0) sys_seen = 1'b1;
         prev = pll_reset_o;
         tick();
      end
      n_cmp++;
      if (rises != 2 || rise_t[0] != 36) begin
         n_bad++;
         $display("FAIL timeout_pulse_starts: got %0d rises first at %0d want 2 at 36", rises, rise_t[0]);
      end
      n_cmp++;
      if (rise_t[1] - rise_t[0] != 36) begin
         n_bad++;
         $display("FAIL timeout_pulse_spacing: got %0d want 36", rise_t[1] - rise_t[0]);
      end
      n_cmp++;
      if (highs != 12) begin
         n_bad++;
         $display("FAIL timeout_high_cycles: got %0d want 12", highs);
      end
      n_cmp++;
      if (timeout_count_o !== 8'd2 || relock_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL timeout_counters: got to=%0d re=%0d want 2/0", timeout_count_o, relock_count_o);
      end
      n_cmp++;
      if (sys_seen) begin
         n_bad++;
         $display("FAIL timeout_sys_held: got sys_rst_n high want low throughout");
      end
   endtask

   task automatic test_relock();
      int n;
      int highs;
      bit ok;
      bit all_ok;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      pll_lock_i = 1'b1;
      wait_sys(1'b1, 40, n, ok);
      pll_lock_i = 1'b0;
      wait_sys(1'b0, 10, n, ok);
      n_cmp++;
      if (!ok || n != 3 || pll_reset_o !== 1'b1 || locked_o !== 1'b0) begin
         n_bad++;
         $display("FAIL relock_same_edge: got n=%0d ok=%0d pll_reset=%b locked=%b want 3/1/1/0", n, ok, pll_reset_o, locked_o);
      end
      highs = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pll_reset_o === 1'b1) highs++;
      end
      n_cmp++;
      if (highs != 4) begin
         n_bad++;
         $display("FAIL relock_pulse_width: got %0d want 4", highs);
      end
      n_cmp++;
      if (relock_count_o !== 8'd1 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL relock_count_one: got re=%0d to=%0d want 1/0", relock_count_o, timeout_count_o);
      end
      all_ok = 1'b1;
      for (int i = 0; i < 299; i++) begin
         pll_lock_i = 1'b1;
         wait_sys(1'b1, 40, n, ok);
         if (!ok) all_ok = 1'b0;
         pll_lock_i = 1'b0;
         wait_sys(1'b0, 10, n, ok);
         if (!ok) all_ok = 1'b0;
         if (i == 252) begin
            n_cmp++;
            if (relock_count_o !== 8'd254) begin
               n_bad++;
               $display("FAIL relock_count_254: got %0d want 254", relock_count_o);
            end
         end
      end
      n_cmp++;
      if (!all_ok) begin
         n_bad++;
         $display("FAIL relock_loop_waits: got a timed-out wait want none");
      end
      n_cmp++;
      if (relock_count_o !== 8'd255) begin
         n_bad++;
         $display("FAIL relock_saturate: got %0d want 255", relock_count_o);
      end
   endtask

   task automatic test_sw_reset();
      int   n;
      bit   ok;
      int   highs;
      logic last_hi;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      pll_lock_i = 1'b1;
      wait_sys(1'b1, 40, n, ok);
      pll_lock_i = 1'b0;
      tick();
      tick();
      sw_reset_i = 1'b1;
      tick();
      sw_reset_i = 1'b0;
      n_cmp++;
      if (pll_reset_o !== 1'b1 || sys_rst_n_o !== 1'b0) begin
         n_bad++;
         $display("FAIL sw_enter_prst: got pll_reset=%b sys=%b want 1/0", pll_reset_o, sys_rst_n_o);
      end
      n_cmp++;
      if (relock_count_o !== 8'd0 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL sw_no_count: got re=%0d to=%0d want 0/0", relock_count_o, timeout_count_o);
      end
      highs = 1;
      tick();
      if (pll_reset_o === 1'b1) highs++;
      tick();
      if (pll_reset_o === 1'b1) highs++;
      sw_reset_i = 1'b1;
      last_hi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         sw_reset_i = 1'b0;
         if (pll_reset_o === 1'b1) highs++;
         if (i == 7) last_hi = pll_reset_o;
      end
      n_cmp++;
      if (highs != 7 || last_hi !== 1'b0) begin
         n_bad++;
         $display("FAIL sw_restart_pulse: got %0d high cycles want 7", highs);
      end
   endtask

   task automatic test_async_reset();
      int n;
      bit ok;
      do_reset();
      for (int i = 0; i < 40; i++) tick();
      pll_lock_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if (timeout_count_o !== 8'd1) begin
         n_bad++;
         $display("FAIL async_pre_timeout: got %0d want 1", timeout_count_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pll_reset_o, sys_rst_n_o, locked_o} !== 3'b100 || timeout_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL async_in_stable: got rst/sys/lck=%b%b%b to=%0d want 100 0", pll_reset_o, sys_rst_n_o, locked_o, timeout_count_o);
      end
      tick();
      rst_n      = 1'b1;
      pll_lock_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      pll_lock_i = 1'b1;
      wait_sys(1'b1, 40, n, ok);
      pll_lock_i = 1'b0;
      wait_sys(1'b0, 10, n, ok);
      pll_lock_i = 1'b1;
      wait_sys(1'b1, 40, n, ok);
      n_cmp++;
      if (!ok || relock_count_o !== 8'd1) begin
         n_bad++;
         $display("FAIL async_pre_run: got ok=%0d re=%0d want 1/1", ok, relock_count_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pll_reset_o, sys_rst_n_o, locked_o} !== 3'b100 || relock_count_o !== 8'd0) begin
         n_bad++;
         $display("FAIL async_in_run: got rst/sys/lck=%b%b%b re=%0d want 100 0", pll_reset_o, sys_rst_n_o, locked_o, relock_count_o);
      end
      tick();
      tick();
      n_cmp++;
      if (sys_rst_n_o !== 1'b0 || locked_o !== 1'b0) begin
         n_bad++;
         $display("FAIL async_held: got sys=%b locked=%b want 0/0", sys_rst_n_o, locked_o);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      pll_lock_i = 1'b0;
      sw_reset_i = 1'b0;
      test_reset();
      test_lock_glitch();
      test_timeout();
      test_relock();
      test_sw_reset();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
